quant_tile_ctrl: RTL and testbench

Tile-level sequencer for the 8-bit activation quantizer. It buffers one tile of 32-bit activations, finds the tile maximum, streams the tile through the quantizer with that maximum held on its max input, and emits the resulting 8-bit indices with valid/last/done framing. It sits between the activation producer (post-ReLU accumulator output) and the quantized-activation writer, and it owns the quantizer's i_max/i_activation inputs.

---
 rtl/quant_tile_ctrl.sv | 138 +++++++++++++
 tb/tb_quant_tile_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_tile_ctrl.sv
// quant_tile_ctrl: buffers one activation tile, finds its maximum and
// streams it through the 8-bit quantizer with valid/last/done framing.
module quant_tile_ctrl #(
    parameter int TILE = 16,
    parameter int LAT  = 9,
    parameter int LW   = $clog2(TILE) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic          i_act_valid,
    input  logic [31:0]   i_act,
    output logic          o_act_ready,
    output logic          o_busy,
    output logic [31:0]   q_max,
    output logic [31:0]   q_activation,
    input  logic [7:0]    q_index,
    output logic [7:0]    o_index,
    output logic          o_valid,
    output logic          o_last,
    output logic          o_done,
    output logic [31:0]   o_max
);

    localparam int AW = $clog2(TILE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] len;
    logic [LW-1:0] wr_cnt;
    logic [LW-1:0] rd_cnt;
    logic [31:0]   run_max;
    logic [31:0]   mem [TILE];
    logic [LAT:0]  vsr;
    logic [LAT:0]  lsr;

    logic          start_ok;
    logic [LW-1:0] len_sat;
    logic          acc;
    logic          load_end;
    logic          issue_end;
    logic [31:0]   max_nxt;

    assign start_ok  = i_start && (i_len != '0);
    assign len_sat   = (i_len > LW'(TILE)) ? LW'(TILE) : i_len;
    assign acc       = (state == LOAD) && i_act_valid;
    assign load_end  = acc && (wr_cnt == len - LW'(1));
    assign issue_end = (state == ISSUE) && (rd_cnt == len - LW'(1));
    assign max_nxt   = (i_act > run_max) ? i_act : run_max;

    assign o_act_ready  = (state == LOAD);
    assign o_busy       = (state != IDLE);
    assign q_activation = (state == ISSUE) ? mem[rd_cnt[AW-1:0]] : '0;
    assign q_max        = (state == ISSUE) ? o_max : '0;
    assign o_valid      = vsr[LAT];
    assign o_last       = lsr[LAT];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: DRAIN ends the cycle after the last element leaves.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok)  state_nxt = LOAD;
            LOAD:    if (load_end)  state_nxt = ISSUE;
            ISSUE:   if (issue_end) state_nxt = DRAIN;
            DRAIN:   if (o_done)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Length, counters, running maximum and the held tile maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len     <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            run_max <= '0;
            o_max   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        len     <= len_sat;
                        wr_cnt  <= '0;
                        run_max <= '0;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        wr_cnt  <= wr_cnt + LW'(1);
                        run_max <= max_nxt;
                    end
                    if (load_end) begin
                        o_max  <= max_nxt;
                        rd_cnt <= '0;
                    end
                end
                ISSUE:   rd_cnt <= rd_cnt + LW'(1);
                default: ;
            endcase
        end
    end

    // Tile buffer; contents are only meaningful after a LOAD.
    always_ff @(posedge clk) begin
        if (acc) mem[wr_cnt[AW-1:0]] <= i_act;
    end

    // Valid/last tracking aligned to quantizer latency, plus output regs.
    // A zero tile maximum forces index 0 to hide the divide-by-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsr     <= '0;
            lsr     <= '0;
            o_index <= '0;
            o_done  <= 1'b0;
        end else begin
            vsr     <= {vsr[LAT-1:0], state == ISSUE};
            lsr     <= {lsr[LAT-1:0], issue_end};
            o_index <= (vsr[LAT-1] && (o_max != '0)) ? q_index : '0;
            o_done  <= lsr[LAT];
        end
    end

endmodule

// File: tb/tb_quant_tile_ctrl.sv
// tb_quant_tile_ctrl: directed scenarios with a behavioural quantizer
// (index = act*255/max, 0xFF on max=0) behind the quantizer ports.
module tb_quant_tile_ctrl;

    localparam int TILE = 16;
    localparam int LAT  = 9;
    localparam int LW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_len = '0;
    logic          i_act_valid = 1'b0;
    logic [31:0]   i_act = '0;
    logic          o_act_ready;
    logic          o_busy;
    logic [31:0]   q_max;
    logic [31:0]   q_activation;
    logic [7:0]    q_index;
    logic [7:0]    o_index;
    logic          o_valid;
    logic          o_last;
    logic          o_done;
    logic [31:0]   o_max;

    quant_tile_ctrl #(.TILE(TILE), .LAT(LAT), .LW(LW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
        .i_act_valid(i_act_valid), .i_act(i_act),
        .o_act_ready(o_act_ready), .o_busy(o_busy),
        .q_max(q_max), .q_activation(q_activation), .q_index(q_index),
        .o_index(o_index), .o_valid(o_valid), .o_last(o_last),
        .o_done(o_done), .o_max(o_max)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] qf(input logic [31:0] a, input logic [31:0] m);
        logic [63:0] r;
        if (m == 0) return 8'hFF;
        r = (64'(a) * 64'd255) / 64'(m);
        return (r > 64'd255) ? 8'hFF : r[7:0];
    endfunction

    logic [7:0] qpipe [LAT];
    always @(posedge clk) begin
        qpipe[0] <= qf(q_activation, q_max);
        for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
    end
    assign q_index = qpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  vq [$];
    logic        lq [$];
    int          cq [$];
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic [31:0] acts [32];
    int          last_acc = 0;
    int          n_acc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (o_valid) begin
            vq.push_back(o_index);
            lq.push_back(o_last);
            cq.push_back(cyc);
        end
        if (o_done) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic clear_q();
        vq.delete();
        lq.delete();
        cq.delete();
    endtask

    // Called #1 into a cycle: pulses i_start now, then feeds acts[].
    task automatic send(input int req_len, input int offer, input bit gaps);
        int k;
        int g;
        bit v;
        i_start = 1'b1;
        i_len = LW'(req_len);
        @(posedge clk); #1;
        i_start = 1'b0;
        i_len = '0;
        n_acc = 0;
        k = 0;
        g = 0;
        while (k < offer && g < 200) begin
            v = gaps ? (g % 2 == 0) : 1'b1;
            i_act_valid = v;
            i_act = acts[k];
            i_start = gaps && !v;
            i_len = LW'(2);
            if (v && o_act_ready) begin
                last_acc = cyc;
                n_acc++;
                k++;
            end else if (n_acc > 0 && !o_act_ready) begin
                break;
            end
            @(posedge clk); #1;
            g++;
        end
        i_act_valid = 1'b0;
        i_start = 1'b0;
        i_len = '0;
        i_act = '0;
    endtask

    // Returns #1 into the cycle after o_done.
    task automatic wait_done();
        int d0;
        int g;
        d0 = done_cnt;
        g = 0;
        while (done_cnt == d0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        n_chk++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL done_timeout: no o_done within %0d cycles", g);
        end
    endtask

    task automatic test_reset();
        int snap;
        #12;
        n_chk++; if ({o_act_ready, o_busy, o_valid, o_last, o_done} !== 5'b0) begin n_fail++; $display("FAIL por_flags: got %b want 00000", {o_act_ready, o_busy, o_valid, o_last, o_done}); end
        n_chk++; if (o_max !== 32'd0) begin n_fail++; $display("FAIL por_omax: got %0h want 0", o_max); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) acts[k] = 32'(16 * k + 16);
        send(16, 16, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        n_chk++; if (q_activation === 32'd0) begin n_fail++; $display("FAIL pre_rst_issue: got q_activation %0h want nonzero", q_activation); end
        rst = 1'b0;
        #1;
        n_chk++; if ({o_act_ready, o_busy, o_valid, o_last, o_done} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", {o_act_ready, o_busy, o_valid, o_last, o_done}); end
        n_chk++; if (o_index !== 8'd0) begin n_fail++; $display("FAIL rst_index: got %0h want 0", o_index); end
        n_chk++; if (o_max !== 32'd0) begin n_fail++; $display("FAIL rst_omax: got %0h want 0", o_max); end
        n_chk++; if (q_max !== 32'd0 || q_activation !== 32'd0) begin n_fail++; $display("FAIL rst_qport: got %0h/%0h want 0/0", q_max, q_activation); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_q();
        snap = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        n_chk++; if (vq.size() != 0) begin n_fail++; $display("FAIL rst_no_valid: got %0d valids want 0", vq.size()); end
        n_chk++; if (done_cnt != snap) begin n_fail++; $display("FAIL rst_no_done: got %0d dones want 0", done_cnt - snap); end
    endtask

    task automatic test_basic();
        int t0;
        int s;
        logic [7:0] ex [4];
        ex = '{8'd0, 8'd63, 8'd127, 8'd255};
        acts[0] = 32'd0; acts[1] = 32'd50; acts[2] = 32'd100; acts[3] = 32'd200;
        clear_q();
        t0 = cyc;
        send(4, 4, 1'b0);
        s = last_acc + 1;
        n_chk++; if (last_acc != t0 + 4) begin n_fail++; $display("FAIL basic_load_time: got %0d want %0d", last_acc - t0, 4); end
        n_chk++; if (o_max !== 32'd200) begin n_fail++; $display("FAIL basic_omax: got %0d want 200", o_max); end
        wait_done();
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b want 0", o_busy); end
        n_chk++; if (vq.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", vq.size()); end
        for (int i = 0; i < 4 && i < vq.size(); i++) begin
            n_chk++; if (vq[i] !== ex[i]) begin n_fail++; $display("FAIL basic_idx%0d: got %0d want %0d", i, vq[i], ex[i]); end
            n_chk++; if (cq[i] != s + LAT + 1 + i) begin n_fail++; $display("FAIL basic_time%0d: got %0d want %0d", i, cq[i], s + LAT + 1 + i); end
            n_chk++; if (lq[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last%0d: got %b want %b", i, lq[i], i == 3); end
        end
        n_chk++; if (done_cyc != s + 3 + LAT + 2) begin n_fail++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, s + 3 + LAT + 2); end
        n_chk++; if (done_cyc + 1 != t0 + 1 + 4 + 4 + LAT + 2) begin n_fail++; $display("FAIL basic_period: got %0d want %0d", done_cyc + 1 - t0, 1 + 4 + 4 + LAT + 2); end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 16; k++) acts[k] = 32'(16 * k + 16);
        clear_q();
        send(16, 16, 1'b1);
        i_start = 1'b1;
        i_len = LW'(3);
        @(posedge clk); #1;
        i_start = 1'b0;
        i_len = '0;
        n_chk++; if (n_acc != 16) begin n_fail++; $display("FAIL gaps_accepted: got %0d want 16", n_acc); end
        n_chk++; if (o_max !== 32'd256) begin n_fail++; $display("FAIL gaps_omax: got %0d want 256", o_max); end
        wait_done();
        n_chk++; if (vq.size() != 16) begin n_fail++; $display("FAIL gaps_count: got %0d want 16", vq.size()); end
        for (int i = 0; i < 16 && i < vq.size(); i++) begin
            n_chk++; if (vq[i] !== 8'(16 * i + 15)) begin n_fail++; $display("FAIL gaps_idx%0d: got %0d want %0d", i, vq[i], 16 * i + 15); end
            n_chk++; if (cq[i] != cq[0] + i) begin n_fail++; $display("FAIL gaps_contig%0d: got %0d want %0d", i, cq[i], cq[0] + i); end
        end
        n_chk++; if (vq.size() == 16 && lq[15] !== 1'b1) begin n_fail++; $display("FAIL gaps_last: got %b want 1", lq[15]); end
        repeat (4) @(posedge clk);
        #1;
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL gaps_extra_start: got busy %b want 0", o_busy); end
    endtask

    task automatic test_zero();
        acts[0] = 32'd0; acts[1] = 32'd0; acts[2] = 32'd0;
        clear_q();
        send(3, 3, 1'b0);
        n_chk++; if (o_max !== 32'd0) begin n_fail++; $display("FAIL zero_omax: got %0h want 0", o_max); end
        wait_done();
        n_chk++; if (vq.size() != 3) begin n_fail++; $display("FAIL zero_count: got %0d want 3", vq.size()); end
        for (int i = 0; i < 3 && i < vq.size(); i++) begin
            n_chk++; if (vq[i] !== 8'd0) begin n_fail++; $display("FAIL zero_idx%0d: got %0d want 0", i, vq[i]); end
        end
        n_chk++; if (vq.size() == 3 && lq[2] !== 1'b1) begin n_fail++; $display("FAIL zero_last: got %b want 1", lq[2]); end
    endtask

    task automatic test_len_edges();
        i_start = 1'b1;
        i_len = '0;
        @(posedge clk); #1;
        i_start = 1'b0;
        n_chk++; if (o_busy !== 1'b0 || o_act_ready !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got busy %b ready %b want 0 0", o_busy, o_act_ready); end
        for (int k = 0; k < 16; k++) acts[k] = 32'(1000 + k);
        for (int k = 16; k < 20; k++) acts[k] = 32'd5000;
        clear_q();
        send(31, 20, 1'b0);
        n_chk++; if (n_acc != 16) begin n_fail++; $display("FAIL sat_accepted: got %0d want 16", n_acc); end
        n_chk++; if (o_max !== 32'd1015) begin n_fail++; $display("FAIL sat_omax: got %0d want 1015", o_max); end
        wait_done();
        n_chk++; if (vq.size() != 16) begin n_fail++; $display("FAIL sat_count: got %0d want 16", vq.size()); end
        if (vq.size() == 16) begin
            n_chk++; if (vq[0] !== 8'd251) begin n_fail++; $display("FAIL sat_idx0: got %0d want 251", vq[0]); end
            n_chk++; if (vq[15] !== 8'd255 || lq[15] !== 1'b1) begin n_fail++; $display("FAIL sat_idx15: got %0d/%b want 255/1", vq[15], lq[15]); end
        end
        acts[0] = 32'hFFFF_FFFF;
        clear_q();
        send(1, 1, 1'b0);
        n_chk++; if (o_max !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL len1_omax: got %0h want ffffffff", o_max); end
        wait_done();
        n_chk++; if (vq.size() != 1) begin n_fail++; $display("FAIL len1_count: got %0d want 1", vq.size()); end
        if (vq.size() == 1) begin
            n_chk++; if (vq[0] !== 8'd255 || lq[0] !== 1'b1) begin n_fail++; $display("FAIL len1_idx: got %0d/%b want 255/1", vq[0], lq[0]); end
        end
    endtask

    task automatic test_back_to_back();
        acts[0] = 32'd10; acts[1] = 32'd20;
        clear_q();
        send(2, 2, 1'b0);
        wait_done();
        n_chk++; if (vq.size() != 2) begin n_fail++; $display("FAIL b2b_a_count: got %0d want 2", vq.size()); end
        if (vq.size() == 2) begin
            n_chk++; if (vq[0] !== 8'd127 || vq[1] !== 8'd255) begin n_fail++; $display("FAIL b2b_a_idx: got %0d,%0d want 127,255", vq[0], vq[1]); end
        end
        clear_q();
        acts[0] = 32'd1000; acts[1] = 32'd250;
        send(2, 2, 1'b0);
        n_chk++; if (n_acc != 2) begin n_fail++; $display("FAIL b2b_b_start: got %0d accepted want 2", n_acc); end
        n_chk++; if (o_max !== 32'd1000) begin n_fail++; $display("FAIL b2b_b_omax: got %0d want 1000", o_max); end
        wait_done();
        n_chk++; if (vq.size() != 2) begin n_fail++; $display("FAIL b2b_b_count: got %0d want 2", vq.size()); end
        if (vq.size() == 2) begin
            n_chk++; if (vq[0] !== 8'd255 || vq[1] !== 8'd63) begin n_fail++; $display("FAIL b2b_b_idx: got %0d,%0d want 255,63", vq[0], vq[1]); end
            n_chk++; if (lq[0] !== 1'b0 || lq[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_b_last: got %b%b want 01", lq[0], lq[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_zero();
        test_len_edges();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
